// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, parameter
// defaults and the next-state-to-output decode.
package rst_seq_pkg;

  localparam int unsigned DEF_HOLD_CYCLES  = 16;
  localparam int unsigned DEF_STAGE_GAP    = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT = 1024;
  localparam int          CNT_W            = 16;

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_REL_CORE   = 3'd2,
    ST_REL_PERIPH = 3'd3,
    ST_REL_LASER  = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } rst_state_e;

  typedef struct packed {
    logic core_n;
    logic periph_n;
    logic laser_n;
    logic done;
    logic fault;
  } rst_outs_t;

  // Release levels are cumulative, so the outputs can never leave out of order.
  function automatic rst_outs_t decode_outs(input rst_state_e st);
    rst_outs_t o;
    o = '0;
    case (st)
      ST_REL_CORE:   o.core_n = 1'b1;
      ST_REL_PERIPH: begin
        o.core_n   = 1'b1;
        o.periph_n = 1'b1;
      end
      ST_REL_LASER:  begin
        o.core_n   = 1'b1;
        o.periph_n = 1'b1;
        o.laser_n  = 1'b1;
      end
      ST_RUN:        begin
        o.core_n   = 1'b1;
        o.periph_n = 1'b1;
        o.laser_n  = 1'b1;
        o.done     = 1'b1;
      end
      ST_FAULT:      o.fault = 1'b1;
      default:       o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by rstn.
module sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/rst_sequencer.sv
// Power-up reset sequencer: holds all resets, waits for PLL lock, then
// releases core, peripheral and laser resets in order with a fixed gap.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned STAGE_GAP    = DEF_STAGE_GAP,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pll_lock,
  input  logic       fault_in,
  input  logic       sw_reset_req,
  output logic       rst_core_n,
  output logic       rst_periph_n,
  output logic       rst_laser_n,
  output logic       seq_done,
  output logic       seq_fault,
  output logic [2:0] seq_state
);

  logic lock_s;
  logic fault_s;

  sync2 u_sync_lock (
    .clk  (clk),
    .rstn (rstn),
    .d    (pll_lock),
    .q    (lock_s)
  );

  sync2 u_sync_fault (
    .clk  (clk),
    .rstn (rstn),
    .d    (fault_in),
    .q    (fault_s)
  );

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rst_outs_t        outs_q, outs_d;

  logic expired;
  logic lock_lost;
  logic restart;

  function automatic logic [CNT_W-1:0] load_val(input rst_state_e st);
    logic [CNT_W-1:0] v;
    case (st)
      ST_HOLD:       v = CNT_W'(HOLD_CYCLES);
      ST_WAIT_LOCK:  v = CNT_W'(LOCK_TIMEOUT);
      ST_REL_CORE,
      ST_REL_PERIPH,
      ST_REL_LASER:  v = CNT_W'(STAGE_GAP);
      default:       v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    restart   = 1'b0;
    expired   = (cnt_q <= CNT_W'(1));
    lock_lost = 1'b0;

    case (state_q)
      ST_HOLD:       if (expired) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)       state_d = ST_REL_CORE;
        else if (expired) state_d = ST_FAULT;
      end
      ST_REL_CORE:   if (expired) state_d = ST_REL_PERIPH;
      ST_REL_PERIPH: if (expired) state_d = ST_REL_LASER;
      ST_REL_LASER:  if (expired) state_d = ST_RUN;
      default:       state_d = state_q;
    endcase

    case (state_q)
      ST_REL_CORE, ST_REL_PERIPH, ST_REL_LASER, ST_RUN: lock_lost = !lock_s;
      default:                                          lock_lost = 1'b0;
    endcase

    // Fault outranks restart requests; FAULT itself only leaves via rstn.
    if (state_q != ST_FAULT && (sw_reset_req || lock_lost)) begin
      state_d = ST_HOLD;
      restart = 1'b1;
    end
    if (fault_s) begin
      state_d = ST_FAULT;
      restart = 1'b0;
    end

    if (restart || state_d != state_q) begin
      cnt_d = load_val(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    outs_d = decode_outs(state_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_HOLD;
      cnt_q   <= CNT_W'(HOLD_CYCLES);
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  assign rst_core_n   = outs_q.core_n;
  assign rst_periph_n = outs_q.periph_n;
  assign rst_laser_n  = outs_q.laser_n;
  assign seq_done     = outs_q.done;
  assign seq_fault    = outs_q.fault;
  assign seq_state    = state_q;

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, meaning: cycles all resets are held after entry to HOLD; legal range 2..65535.
REQ-002 Parameter STAGE_GAP, default 8, meaning: cycles between successive reset-release stages; legal range 1..65535.
REQ-003 Parameter LOCK_TIMEOUT, default 1024, meaning: maximum cycles spent in WAIT_LOCK before FAULT; legal range 1..65535.
REQ-004 Port clk, input, 1, meaning: system clock.
REQ-005 Port rstn, input, 1, meaning: reset, asynchronous, active-low; driven by the filtered board-reset output.
REQ-006 Port pll_lock, input, 1, meaning: PLL lock, asynchronous to clk.
REQ-007 Port fault_in, input, 1, meaning: external safety fault, asynchronous, active-high.
REQ-008 Port sw_reset_req, input, 1, meaning: single-cycle synchronous request to re-run the sequence.
REQ-009 Port rst_core_n, output, 1, meaning: core-logic reset, active-low, released first.
REQ-010 Port rst_periph_n, output, 1, meaning: peripheral reset, active-low, released second.
REQ-011 Port rst_laser_n, output, 1, meaning: laser-driver reset, active-low, released last.
REQ-012 Port seq_done, output, 1, meaning: high only in RUN.
REQ-013 Port seq_fault, output, 1, meaning: high only in FAULT.
REQ-014 Port seq_state, output, 3, meaning: current state encoding, for debug.

Function
REQ-015 pll_lock and fault_in SHALL each pass through a two-flop synchronizer (reset to 0) before use; the synchronized signals are lock_s and fault_s.
REQ-016 States SHALL be HOLD, WAIT_LOCK, REL_CORE, REL_PERIPH, REL_LASER, RUN and FAULT.
REQ-017 HOLD: counts HOLD_CYCLES cycles with all resets asserted, then goes to WAIT_LOCK.
REQ-018 WAIT_LOCK: goes to REL_CORE on the first cycle lock_s=1; goes to FAULT after LOCK_TIMEOUT cycles without lock.
REQ-019 REL_CORE, REL_PERIPH and REL_LASER: each lasts STAGE_GAP cycles, then advances; REL_LASER advances to RUN.
REQ-020 Outputs SHALL be registered and decoded from the next state, as follows:
- rst_core_n=1 in REL_CORE and all later non-fault states.
- rst_periph_n=1 from REL_PERIPH onward.
- rst_laser_n=1 from REL_LASER onward.
REQ-021 With lock_s already 1, rst_core_n SHALL rise at clk edge HOLD_CYCLES+1, where edge 1 is the first rising edge with rstn high.
REQ-022 Loss of lock_s in any state after WAIT_LOCK (excluding FAULT) SHALL return to HOLD and assert all three resets on the same edge.
REQ-023 sw_reset_req=1 in any state except FAULT SHALL return to HOLD with all resets asserted on the next edge.
REQ-024 fault_s=1 in any state SHALL go to FAULT with all resets asserted.
REQ-025 FAULT SHALL be sticky and exited only by rstn.
REQ-026 Priority when events coincide: fault_s > lock loss = sw_reset_req > normal advance.
REQ-027 A single 16-bit down-counter SHALL be shared by all timed states and reloaded on every state change.
REQ-028 Reset outputs SHALL never release out of order.
REQ-029 Reset outputs SHALL be glitch-free, being direct flop outputs.

Reset
REQ-030 While rstn=0, the following SHALL hold:
- State = HOLD and counter = HOLD_CYCLES.
- rst_core_n, rst_periph_n and rst_laser_n = 0.
- seq_done = 0 and seq_fault = 0.
- seq_state = HOLD encoding.
- Synchronizer flops = 0.
REQ-031 Assertion of rstn mid-sequence, including in RUN or FAULT, SHALL immediately (asynchronously) force the reset values above.

Structure
REQ-032 The state enumeration, its 3-bit encodings (HOLD=0 ... FAULT=6) and the parameter defaults SHALL live in shared package rst_seq_pkg.
REQ-033 The two-flop synchronizer SHALL be a sub-module named sync2, instantiated twice.

Verification
REQ-034 The bench SHALL cover the following scenarios:
- Release rstn with pll_lock=1 and defaults -> rst_core_n rises at edge 17, rst_periph_n at 25, rst_laser_n at 33; seq_done=1 from edge 41.
- Hold pll_lock=0 with LOCK_TIMEOUT=1024 -> seq_fault=1 after 1024 WAIT_LOCK cycles, all resets low; raising pll_lock does not exit FAULT.
- Drop pll_lock in RUN -> all resets 0 within 3 edges, then the full sequence repeats when lock returns.
- Pulse sw_reset_req in REL_PERIPH -> HOLD on the next edge, then 16 hold cycles before WAIT_LOCK.
- Assert fault_in and sw_reset_req together in RUN -> FAULT wins; seq_fault=1 and seq_done=0.
- Pulse rstn low for one cycle in FAULT -> outputs go to reset values asynchronously, then a normal sequence follows.
